// File: rtl/iob_bus_arbiter.sv
// Two-master (instruction=m0, data=m1) round-robin arbiter onto one IOb slave port.
// Latency: m*_valid at cycle N -> s_valid at N+1; master ready in the same cycle as s_ready.
// Backpressure: one outstanding transaction; the loser waits with valid held; optional watchdog.
//
// Ports:
//   clk, resetn           clock and synchronous active-low reset
//   m0_* / m1_*           IOb master requests (valid/addr/wdata/wstrb) and responses (rdata/ready)
//   s_*                   IOb slave request and response
//   grant                 one-hot registered owner (00 = none); err = sticky watchdog flag
module iob_bus_arbiter #(
  parameter int                   ADDR_W     = 32,
  parameter int                   DATA_W     = 32,
  parameter int                   TIMEOUT_W  = 8,
  parameter int                   TIMEOUT_EN = 1,
  parameter logic [DATA_W-1:0]    ERR_DATA   = 'hDEADC0DE
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_valid,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_ready,
  input  logic                  m1_valid,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_ready,
  output logic                  s_valid,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic                  s_ready,
  output logic [1:0]            grant,
  output logic                  err
);

  localparam bit WDOG = (TIMEOUT_EN != 0);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t               state;
  logic                 last_grant;   // 0 = m0 served last, 1 = m1 served last
  logic [TIMEOUT_W-1:0] cnt;
  logic                 in_req;
  logic                 timeout_hit;
  logic                 done;
  logic [DATA_W-1:0]    resp_data;

  assign in_req = (state == REQ);

  // A real s_ready in the terminal-count cycle takes priority over the watchdog.
  assign timeout_hit = WDOG && in_req && !s_ready && (cnt == {TIMEOUT_W{1'b1}});
  assign done        = in_req && (s_ready || timeout_hit);
  assign resp_data   = timeout_hit ? ERR_DATA : s_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      cnt        <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // m0 wins when alone, or on a tie if m1 was served last.
          if (m0_valid && (!m1_valid || last_grant)) begin
            grant      <= 2'b01;
            last_grant <= 1'b0;
            state      <= REQ;
          end else if (m1_valid) begin
            grant      <= 2'b10;
            last_grant <= 1'b1;
            state      <= REQ;
          end
          cnt <= '0;
        end
        REQ: begin
          if (s_ready || timeout_hit) begin
            state <= RELEASE;
            grant <= 2'b00;
            cnt   <= '0;
            if (timeout_hit) begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          // One dead cycle so a master dropping valid late is not re-issued.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  assign s_valid = in_req;
  assign s_addr  = grant[1] ? m1_addr  : (grant[0] ? m0_addr  : '0);
  assign s_wdata = grant[1] ? m1_wdata : (grant[0] ? m0_wdata : '0);
  assign s_wstrb = grant[1] ? m1_wstrb : (grant[0] ? m0_wstrb : '0);

  assign m0_ready = done && grant[0];
  assign m1_ready = done && grant[1];
  assign m0_rdata = (in_req && grant[0]) ? resp_data : '0;
  assign m1_rdata = (in_req && grant[1]) ? resp_data : '0;

endmodule

// File: tb/tb_iob_bus_arbiter.sv
module tb_iob_bus_arbiter;

  localparam int TW    = 4;
  localparam int LIMIT = (1 << TW) - 1;
  localparam logic [31:0] ERRW = 32'hDEADC0DE;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [1:0]  grant;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iob_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_W(TW), .TIMEOUT_EN(1), .ERR_DATA(ERRW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .err(err)
  );

  // ---------------- transaction-level reference model ----------------
  int   owner  = -1;   // master currently holding the slave, -1 = none
  int   waited = 0;    // cycles spent by the owner without a response
  bit   gap    = 0;    // a dead cycle follows every completion
  int   prefer = 0;    // master that wins the next tie
  bit   err_m  = 0;
  bit   done0  = 0, done1 = 0;

  function automatic logic [137:0] model_exp();
    logic to;
    logic [1:0]  g;
    logic [31:0] sa, sw, r0d, r1d, resp;
    logic [3:0]  ss;
    logic        r0, r1;
    to   = (owner >= 0) && !s_ready && (waited == LIMIT);
    resp = to ? ERRW : s_rdata;
    g = 2'b00; sa = '0; sw = '0; ss = '0; r0 = 1'b0; r1 = 1'b0; r0d = '0; r1d = '0;
    if (owner == 0) begin
      g = 2'b01; sa = m0_addr; sw = m0_wdata; ss = m0_wstrb; r0 = s_ready || to; r0d = resp;
    end else if (owner == 1) begin
      g = 2'b10; sa = m1_addr; sw = m1_wdata; ss = m1_wstrb; r1 = s_ready || to; r1d = resp;
    end
    return {g, err_m, (owner >= 0), sa, sw, ss, r0, r0d, r1, r1d};
  endfunction

  task automatic model_update();
    bit to;
    done0 = 0; done1 = 0;
    if (!resetn) begin
      owner = -1; gap = 0; prefer = 0; waited = 0; err_m = 0;
    end else if (owner >= 0) begin
      to = !s_ready && (waited == LIMIT);
      if (s_ready || to) begin
        if (owner == 0) done0 = 1; else done1 = 1;
        err_m = err_m | to;
        owner = -1;
        gap   = 1;
      end else begin
        waited++;
      end
    end else if (gap) begin
      gap = 0;
    end else if (m0_valid || m1_valid) begin
      owner  = (m0_valid && m1_valid) ? prefer : (m0_valid ? 0 : 1);
      prefer = 1 - owner;
      waited = 0;
    end
  endtask

  function automatic logic [137:0] act_vec();
    return {grant, err, s_valid, s_addr, s_wdata, s_wstrb, m0_ready, m0_rdata, m1_ready, m1_rdata};
  endfunction

  task automatic check(input string name, input logic [137:0] act, input logic [137:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, v0, v1;
    logic [31:0] a0, a1, wd1;
    logic [3:0]  ws1;
    logic        sr;
    logic [31:0] srd;
    logic [1:0]  g;
    logic        sv;
    logic [31:0] sa, sw;
    logic [3:0]  ss;
    logic        r0;
    logic [31:0] rd0;
    logic        r1;
    logic [31:0] rd1;
    logic        e;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, v0, v1, input logic [31:0] a0, a1, wd1, input logic [3:0] ws1,
    input logic sr, input logic [31:0] srd,
    input logic [1:0] g, input logic sv, input logic [31:0] sa, sw, input logic [3:0] ss,
    input logic r0, input logic [31:0] rd0, input logic r1, input logic [31:0] rd1, input logic e);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1; v.wd1 = wd1; v.ws1 = ws1;
    v.sr = sr; v.srd = srd; v.g = g; v.sv = sv; v.sa = sa; v.sw = sw; v.ss = ss;
    v.r0 = r0; v.rd0 = rd0; v.r1 = r1; v.rd1 = rd1; v.e = e;
    return v;
  endfunction

  vec_t tbl[21];

  initial begin
    vec_t v;
    logic [137:0] ev;

    resetn = 1'b0; m0_valid = 0; m1_valid = 0; m0_addr = 0; m1_addr = 0;
    m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0; s_rdata = 0; s_ready = 0;
    #1;
    step(); step();

    // rst v0 v1 a0 a1 wd1 ws1 sr srd | g sv sa sw ss r0 rd0 r1 rd1 e
    tbl[0]  = mk(0,0,0, 0,0,0,0, 0,0,            2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[1]  = mk(1,1,0, 32'h100,0,0,0, 0,0,      2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[2]  = mk(1,1,0, 32'h100,0,0,0, 0,0,      2'b01,1,32'h100,0,0, 0,0,0,0,0);
    tbl[3]  = mk(1,1,0, 32'h100,0,0,0, 1,32'h12345678, 2'b01,1,32'h100,0,0, 1,32'h12345678,0,0,0);
    tbl[4]  = mk(1,0,0, 0,0,0,0, 0,0,            2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[5]  = mk(1,0,0, 0,0,0,0, 0,0,            2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[6]  = mk(0,1,1, 32'h10,32'h20,0,0, 0,0,  2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[7]  = mk(1,1,1, 32'h10,32'h20,0,0, 0,0,  2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[8]  = mk(1,1,1, 32'h10,32'h20,0,0, 1,32'h11, 2'b01,1,32'h10,0,0, 1,32'h11,0,0,0);
    tbl[9]  = mk(1,1,1, 32'h10,32'h20,0,0, 0,0,  2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[10] = mk(1,1,1, 32'h10,32'h20,0,0, 0,0,  2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[11] = mk(1,1,1, 32'h10,32'h20,0,0, 1,32'h22, 2'b10,1,32'h20,0,0, 0,0,1,32'h22,0);
    tbl[12] = mk(1,1,1, 32'h10,32'h20,0,0, 0,0,  2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[13] = mk(1,1,1, 32'h10,32'h20,0,0, 0,0,  2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[14] = mk(1,1,1, 32'h10,32'h20,0,0, 0,0,  2'b01,1,32'h10,0,0, 0,0,0,0,0);
    tbl[15] = mk(1,1,1, 32'h10,32'h20,0,0, 1,32'h33, 2'b01,1,32'h10,0,0, 1,32'h33,0,0,0);
    tbl[16] = mk(1,0,1, 0,32'h2000,32'hA5A5A5A5,4'b0011, 0,0, 2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[17] = mk(1,0,1, 0,32'h2000,32'hA5A5A5A5,4'b0011, 0,0, 2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[18] = mk(1,0,1, 0,32'h2000,32'hA5A5A5A5,4'b0011, 1,0,
                 2'b10,1,32'h2000,32'hA5A5A5A5,4'b0011, 0,0,1,0,0);
    tbl[19] = mk(1,0,0, 0,0,0,0, 0,0,            2'b00,0,0,0,0, 0,0,0,0,0);
    tbl[20] = mk(1,0,0, 0,0,0,0, 1,32'hFF,       2'b00,0,0,0,0, 0,0,0,0,0);

    for (int i = 0; i < 21; i++) begin
      v = tbl[i];
      resetn = v.rst; m0_valid = v.v0; m1_valid = v.v1; m0_addr = v.a0; m1_addr = v.a1;
      m0_wdata = 0; m0_wstrb = 0; m1_wdata = v.wd1; m1_wstrb = v.ws1;
      s_ready = v.sr; s_rdata = v.srd;
      @(negedge clk);
      ev = {v.g, v.e, v.sv, v.sa, v.sw, v.ss, v.r0, v.rd0, v.r1, v.rd1};
      check($sformatf("tbl%0d", i), act_vec(), ev);
      step();
    end

    // ---- watchdog fires after 15 waiting cycles ----
    m0_valid = 1; m0_addr = 32'h300; s_ready = 0; s_rdata = 32'h55;
    @(negedge clk); step();                      // IDLE
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 14) check("to_wait", 138'({m0_ready, m1_ready}), 138'(0));
      if (k == 15) begin
        check("to_ready", 138'({m0_ready, m0_rdata}), 138'({1'b1, ERRW}));
        check("to_err_pre", 138'(err), 138'(0));
      end
      step();
    end
    m0_valid = 0; s_ready = 1; s_rdata = 32'h77;  // late response in RELEASE
    @(negedge clk);
    check("late_rdy", 138'({m0_ready, m1_ready, s_valid}), 138'(0));
    check("err_set", 138'(err), 138'(1));
    step();
    @(negedge clk);                              // spurious s_ready in IDLE
    check("late_rdy2", 138'({m0_ready, m1_ready, s_valid}), 138'(0));
    check("err_sticky", 138'(err), 138'(1));
    step();
    s_ready = 0;

    // ---- s_ready exactly at terminal count wins ----
    resetn = 0; @(negedge clk); step();
    resetn = 1; m1_valid = 1; m1_addr = 32'h400; m1_wstrb = 0;
    @(negedge clk); step();                      // IDLE
    for (int k = 0; k < 16; k++) begin
      s_ready = (k == 15); s_rdata = (k == 15) ? 32'hCAFEF00D : 32'h0;
      @(negedge clk);
      if (k == 15) check("edge_ready", 138'({m1_ready, m1_rdata, m0_ready}), 138'({1'b1, 32'hCAFEF00D, 1'b0}));
      step();
    end
    m1_valid = 0; s_ready = 0;
    @(negedge clk);
    check("edge_noerr", 138'(err), 138'(0));
    step();

    // ---- reset in the middle of a request ----
    m0_valid = 1; m0_addr = 32'h500;
    @(negedge clk); step();                      // IDLE -> REQ
    @(negedge clk);
    check("mid_req", 138'({grant, s_valid}), 138'({2'b01, 1'b1}));
    resetn = 0; step();
    resetn = 1; s_ready = 1; s_rdata = 32'h99;
    @(negedge clk);
    check("post_rst", 138'({grant, s_valid, m0_ready, m1_ready}), 138'(0));
    step();                                      // IDLE -> REQ with fresh request
    s_ready = 1; s_rdata = 32'h4242;
    @(negedge clk);
    check("reissue", 138'({grant, m0_ready, m0_rdata}), 138'({2'b01, 1'b1, 32'h4242}));
    step();
    m0_valid = 0; s_ready = 0;
    @(negedge clk); step();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 4000; c++) begin
      resetn = ($urandom_range(0, 299) != 0);
      if (m0_valid && (done0 || (owner != 0 && $urandom_range(0, 7) == 0))) m0_valid = 0;
      else if (!m0_valid && $urandom_range(0, 2) == 0) begin
        m0_valid = 1; m0_addr = $urandom; m0_wdata = $urandom;
        m0_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      if (m1_valid && (done1 || (owner != 1 && $urandom_range(0, 7) == 0))) m1_valid = 0;
      else if (!m1_valid && $urandom_range(0, 2) == 0) begin
        m1_valid = 1; m1_addr = $urandom; m1_wdata = $urandom;
        m1_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      s_ready = ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;
      @(negedge clk);
      check($sformatf("rnd%0d", c), act_vec(), model_exp());
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
